// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: registered one-hot grant held until done/abandon, then priority rotates.
// Optional forced release after MAX_HOLD grant cycles when RR_GRANT_TIMEOUT_EN is defined.
module rr_grant_ctrl #(
  parameter int N        = 8,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  input  logic           done_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_idx_o,
  output logic           busy_o,
  output logic [IDW-1:0] lowp_o,
  output logic [IDW:0]   pend_cnt_o,
  output logic           timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  if (IDW != $clog2(N)) begin : g_bad_idw
    $error("IDW must equal $clog2(N)");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("MAX_HOLD must be at least 2");
  end

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] idx_q, idx_d;
  logic [IDW-1:0] lowp_q, lowp_d;
  logic [IDW:0]   pend_q;
  logic           rel_normal;
  logic           force_rel;

  // First set request strictly after lowp, wrapping modulo N; lowp itself is checked last.
  function automatic logic [IDW-1:0] pick_winner(input logic [N-1:0] req,
                                                 input logic [IDW-1:0] lowp);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] win;
    win = lowp;
    for (int i = N; i >= 1; i--) begin
      idx = lowp + IDW'(i);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

  function automatic logic [IDW:0] popcount(input logic [N-1:0] v);
    logic [IDW:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + (IDW+1)'(v[i]);
    return cnt;
  endfunction

  assign rel_normal = done_i | ~req_i[idx_q];

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_q, hold_d;
  logic          to_q, to_d;

  assign force_rel = (hold_q == HW'(MAX_HOLD - 1));
  assign timeout_o = to_q;
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    lowp_d  = lowp_q;
`ifdef RR_GRANT_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          idx_d          = pick_winner(req_i, lowp_q);
          gnt_d          = '0;
          gnt_d[idx_d]   = 1'b1;
          state_d        = GRANT;
`ifdef RR_GRANT_TIMEOUT_EN
          hold_d         = '0;
`endif
        end
      end
      GRANT: begin
`ifdef RR_GRANT_TIMEOUT_EN
        hold_d = hold_q + 1'b1;
        to_d   = force_rel & ~rel_normal;
`endif
        if (rel_normal || force_rel) begin
          gnt_d   = '0;
          lowp_d  = idx_q;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      lowp_q  <= IDW'(N - 1);
      pend_q  <= '0;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      lowp_q  <= lowp_d;
      pend_q  <= popcount(req_i);
`ifdef RR_GRANT_TIMEOUT_EN
      hold_q  <= hold_d;
      to_q    <= to_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_idx_o  = idx_q;
  assign busy_o     = (state_q != IDLE);
  assign lowp_o     = lowp_q;
  assign pend_cnt_o = pend_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: vector table plus hand sequences for reset, rotation and timeout.
module tb_rr_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic [2:0] lowp;
  logic [3:0] pend;
  logic       tmo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_grant_ctrl #(.N(8), .IDW(3), .MAX_HOLD(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .done_i(done),
    .gnt_o(gnt), .gnt_idx_o(gnt_idx), .busy_o(busy), .lowp_o(lowp),
    .pend_cnt_o(pend), .timeout_o(tmo)
  );

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       busy;
    logic [2:0] lowp;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 3'd7, 4'd2};
    vecs[1]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b1, 3'd0, 4'd2};
    vecs[2]  = '{8'h81, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 4'd2};
    vecs[3]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 3'd0, 4'd2};
    vecs[4]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 3'd0, 4'd2};
    vecs[5]  = '{8'h01, 1'b0, 8'h00, 3'd7, 1'b1, 3'd7, 4'd1};
    vecs[6]  = '{8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 3'd7, 4'd0};
    vecs[7]  = '{8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 3'd7, 4'd0};
    vecs[8]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 3'd7, 4'd1};
    vecs[9]  = '{8'h00, 1'b0, 8'h00, 3'd3, 1'b1, 3'd3, 4'd0};
    vecs[10] = '{8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 3'd3, 4'd0};
    vecs[11] = '{8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 3'd3, 4'd1};
    vecs[12] = '{8'h40, 1'b1, 8'h00, 3'd6, 1'b1, 3'd6, 4'd1};
    vecs[13] = '{8'h41, 1'b0, 8'h00, 3'd6, 1'b0, 3'd6, 4'd2};
    vecs[14] = '{8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 3'd6, 4'd2};
    vecs[15] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 3'd0, 4'd0};
    vecs[16] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0, 4'd0};
    vecs[17] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0, 4'd0};
    vecs[18] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 3'd0, 4'd1};
    vecs[19] = '{8'h06, 1'b0, 8'h04, 3'd2, 1'b1, 3'd0, 4'd2};
    vecs[20] = '{8'h06, 1'b1, 8'h00, 3'd2, 1'b1, 3'd2, 4'd2};
    vecs[21] = '{8'h06, 1'b0, 8'h00, 3'd2, 1'b0, 3'd2, 4'd2};
    vecs[22] = '{8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 3'd2, 4'd2};
    vecs[23] = '{8'h00, 1'b1, 8'h00, 3'd1, 1'b1, 3'd1, 4'd0};
    vecs[24] = '{8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 3'd1, 4'd0};

    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #12;
    chk("rst_gnt",  gnt, 0);
    chk("rst_idx",  gnt_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lowp", lowp, 7);
    chk("rst_pend", pend, 0);
    chk("rst_tmo",  tmo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 25; v++) begin
      req  = vecs[v].req;
      done = vecs[v].done;
      step();
      chk($sformatf("v%0d_gnt", v),  gnt,     vecs[v].gnt);
      chk($sformatf("v%0d_idx", v),  gnt_idx, vecs[v].idx);
      chk($sformatf("v%0d_busy", v), busy,    vecs[v].busy);
      chk($sformatf("v%0d_lowp", v), lowp,    vecs[v].lowp);
      chk($sformatf("v%0d_pend", v), pend,    vecs[v].pend);
      chk($sformatf("v%0d_tmo", v),  tmo,     0);
    end
    done = 1'b0;

    // Async reset in the middle of a grant.
    req = 8'hFF;
    step();
    chk("mid_gnt", gnt, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt",  gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_lowp", lowp, 7);
    chk("arst_pend", pend, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full rotation with constant requests.
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("rot%0d_gnt", k),  gnt, 8'h01 << (k % 8));
      chk($sformatf("rot%0d_idx", k),  gnt_idx, k % 8);
      chk($sformatf("rot%0d_pend", k), pend, 8);
      step();
      chk($sformatf("rot%0d_hold", k), gnt, 8'h01 << (k % 8));
      done = 1'b1;
      step();
      done = 1'b0;
      chk($sformatf("rot%0d_rel", k),  gnt, 0);
      chk($sformatf("rot%0d_rbsy", k), busy, 1);
      chk($sformatf("rot%0d_lowp", k), lowp, k % 8);
      step();
      chk($sformatf("rot%0d_idle", k), busy, 0);
    end

    req = 8'h20;
    step();
    chk("hold_first", gnt, 8'h20);
`ifdef RR_GRANT_TIMEOUT_EN
    cnt = 1;
    for (int s = 0; s < 40; s++) begin
      step();
      if (gnt != 8'h20) break;
      cnt++;
    end
    chk("to_cycles", cnt, 16);
    chk("to_gnt",    gnt, 0);
    chk("to_pulse",  tmo, 1);
    chk("to_lowp",   lowp, 5);
    step();
    chk("to_clear",  tmo, 0);
    req = 8'h00;
    step();
`else
    cnt = 1;
    for (int s = 0; s < 30; s++) begin
      step();
      if (gnt == 8'h20) cnt++;
    end
    chk("nohold_cycles", cnt, 31);
    chk("nohold_tmo",    tmo, 0);
    req = 8'h00;
    step();
    chk("nohold_lowp", lowp, 5);
    step();
`endif
    chk("end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
